multicycle_addsub: RTL and testbench
====================================

// Module: multicycle_addsub
// PURPOSE
//   Parametrised, multi-cycle two's-complement adder/subtractor for the execute stage.
//   Processes the operands CHUNK bits per clock, carry-chained LSB chunk first, and produces Y86 condition codes.
//   Uses a valid/ready handshake on both input and output.
//   Replaces the fixed 64-bit single-cycle ripple subtractor wherever a shorter critical path is needed.
// PARAMETERS
//   WIDTH  64  operand/result width in bits
//   CHUNK  16  bits processed per cycle; WIDTH % CHUNK == 0 is required
//   NCH    WIDTH/CHUNK (localparam)  number of chunk cycles per operation
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operation request
//   in_ready   out  1      high only in IDLE
//   op         in   1      0 = add (a+b), 1 = subtract (a-b)
//   a          in   WIDTH  first operand
//   b          in   WIDTH  second operand
//   out_valid  out  1      result and flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  a+b or a-b, modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (add: carry; sub: 1 = no borrow)
//   borrow     out  1      sub: ~cout; add: forced 0
//   zf,sf,of   out  1      zero, sign, signed-overflow flags (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst_n==0 at a posedge):
//     - state=IDLE, chunk counter=0, out_valid=0, result=0, cout=0, borrow=0, zf=sf=of=0.
//     - Reset wins over every other event, including mid-operation; any in-flight op is discarded.
//   - FSM states IDLE -> BUSY -> DONE -> IDLE:
//     - IDLE: in_ready=1. If in_valid, capture a, b^{WIDTH{op}}, op; carry=op; cnt=0; go to BUSY.
//     - BUSY: each cycle add chunk[cnt] of a and b' plus carry; write the sum into result[cnt*CHUNK +: CHUNK];
//       update carry; cnt++. After chunk NCH-1: latch cout/borrow/flags, out_valid=1, go to DONE.
//     - DONE: hold result and flags stable while out_ready==0. On out_valid&&out_ready: out_valid=0, go to IDLE.
//   - Latency: the op is accepted on edge T; out_valid is high after edge T+NCH.
//     Minimum spacing between accepts is NCH+2 cycles (DONE->IDLE adds a one-cycle bubble; no bypass).
//   - in_valid outside IDLE is ignored; a/b/op changes after acceptance have no effect.
//   - result bits of chunks not yet computed read 0 during BUSY; consumers must use result only while out_valid.
//   - NCH==1 is legal: a single BUSY cycle.
//   - The chunk carry in is the previous chunk's carry out; carry must propagate correctly across all chunk boundaries.
// CONFIGURATION
//   - ADDSUB_CC_EN defined:
//     - zf = (result==0); sf = result[WIDTH-1].
//     - of = (a[MSB]==b'[MSB]) && (result[MSB]!=a[MSB]), using the captured, possibly inverted b'.
//     - All three flags are registered together with out_valid.
//   - ADDSUB_CC_EN undefined: zf, sf, of are tied to 0 and no flag logic is generated. result/cout/borrow are unchanged.
// TESTING (WIDTH=64, CHUNK=16, ADDSUB_CC_EN defined unless noted)
//   1. add 5+7 -> after 4 cycles out_valid=1, result=12, cout=0, borrow=0, zf=sf=of=0.
//   2. sub 5-7 -> result=0xFFFFFFFFFFFFFFFE, cout=0, borrow=1, sf=1, of=0.
//   3. sub 0x8000000000000000-1 -> result=0x7FFFFFFFFFFFFFFF, of=1, sf=0, cout=1, borrow=0.
//   4. add 0xFFFFFFFFFFFFFFFF+1 -> result=0, cout=1, zf=1 (carry crosses all 4 chunk boundaries).
//   5. out_ready=0 for 3 cycles in DONE with in_valid=1 toggling -> result/flags held, in_ready=0,
//      no new accept; a new op is accepted only after the handshake plus one idle cycle.
//   6. rst_n=0 during the 2nd BUSY cycle -> next cycle out_valid=0, result=0, in_ready=1;
//      following add 3+4 returns 7. Repeat test 1 without ADDSUB_CC_EN -> zf=sf=of=0.

Source files
------------

// File: rtl/multicycle_addsub_if.sv
// -----------------------------------------------------------------------------
// multicycle_addsub_if
//   Request/response bundle for the multi-cycle adder/subtractor.
//   Request side : in_valid, in_ready, op, a, b
//   Response side: out_valid, out_ready, result, cout, borrow, zf, sf, of
//   master modport : the requester/consumer (drives the request, accepts results)
//   slave modport  : the adder/subtractor itself
// -----------------------------------------------------------------------------
interface multicycle_addsub_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             borrow;
   logic             zf;
   logic             sf;
   logic             of;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, cout, borrow, zf, sf, of
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, cout, borrow, zf, sf, of
   );
endinterface

// File: rtl/multicycle_addsub.sv
// -----------------------------------------------------------------------------
// multicycle_addsub
//   Multi-cycle two's-complement adder/subtractor for the execute stage.
//   Operands are added CHUNK bits per clock, LSB chunk first, with the carry
//   chained between chunks. Produces Y86 condition codes.
//
//   Optional feature macro: ADDSUB_CC_EN
//     defined   -> zf/sf/of are computed and registered with out_valid
//     undefined -> zf/sf/of are tied to 0, no flag logic
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : slave side of multicycle_addsub_if
//            in_valid/in_ready/op/a/b         request handshake
//            out_valid/out_ready/result/...   response handshake + flags
// -----------------------------------------------------------------------------
module multicycle_addsub #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   multicycle_addsub_if.slave   bus
);
   localparam int NCH   = WIDTH / CHUNK;
   localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               carry_q;
   logic               op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;        // holds b, or ~b for subtract
   logic [WIDTH-1:0]   result_q;
   logic               out_valid_q;
   logic               cout_q;
   logic               borrow_q;

   logic               accept;
   logic               step;
   logic               last_chunk;
   logic               done_hs;
   logic [CHUNK:0]     chunk_sum;
   logic [WIDTH-1:0]   result_d;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)                  state_d = BUSY;
         BUSY:    if (cnt_q == CNT_W'(NCH - 1))      state_d = DONE;
         DONE:    if (bus.out_ready)                 state_d = IDLE;
         default:                                    state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / control strobes ----------------
   always_comb begin
      bus.in_ready = 1'b0;
      accept       = 1'b0;
      step         = 1'b0;
      last_chunk   = 1'b0;
      done_hs      = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            accept       = bus.in_valid;
         end
         BUSY: begin
            step       = 1'b1;
            last_chunk = (cnt_q == CNT_W'(NCH - 1));
         end
         DONE:    done_hs = bus.out_ready;
         default: ;
      endcase
   end

   // One chunk of the ripple: current chunk of a and b' plus the chained carry.
   assign chunk_sum = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]}
                    + {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, carry_q};

   // Result with the current chunk merged in; flags on the last chunk look at this.
   always_comb begin
      result_d                         = result_q;
      result_d[cnt_q*CHUNK +: CHUNK]   = chunk_sum[CHUNK-1:0];
   end

   // ---------------- operand capture (no reset needed) ----------------
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= bus.a;
         b_q  <= bus.b ^ {WIDTH{bus.op}};
         op_q <= bus.op;
      end
   end

   // ---------------- chunk datapath and response registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         cout_q      <= 1'b0;
         borrow_q    <= 1'b0;
      end else begin
         if (accept) begin
            cnt_q    <= '0;
            carry_q  <= bus.op;        // +1 completes the two's-complement of b
            result_q <= '0;            // untouched chunks read 0 while BUSY
         end else if (step) begin
            result_q <= result_d;
            carry_q  <= chunk_sum[CHUNK];
            if (last_chunk) begin
               cnt_q       <= '0;      // keeps the index in range for NCH==1
               cout_q      <= chunk_sum[CHUNK];
               borrow_q    <= op_q & ~chunk_sum[CHUNK];
               out_valid_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else if (done_hs) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef ADDSUB_CC_EN
   logic zf_q, sf_q, of_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zf_q <= 1'b0;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else if (step && last_chunk) begin
         zf_q <= (result_d == '0);
         sf_q <= result_d[WIDTH-1];
         // Overflow uses the captured b', so subtract is handled like add.
         of_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_d[WIDTH-1] != a_q[WIDTH-1]);
      end
   end

   assign bus.zf = zf_q;
   assign bus.sf = sf_q;
   assign bus.of = of_q;
`else
   assign bus.zf = 1'b0;
   assign bus.sf = 1'b0;
   assign bus.of = 1'b0;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.cout      = cout_q;
   assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_multicycle_addsub.sv
// -----------------------------------------------------------------------------
// tb_multicycle_addsub
//   Directed-vector bench for multicycle_addsub (WIDTH=64, CHUNK=16).
//   Flag expectations follow ADDSUB_CC_EN: zero when the macro is undefined.
// -----------------------------------------------------------------------------
module tb_multicycle_addsub;
   localparam int W   = 64;
   localparam int NCH = 4;
`ifdef ADDSUB_CC_EN
   localparam bit CC = 1'b1;
`else
   localparam bit CC = 1'b0;
`endif

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   multicycle_addsub_if #(.WIDTH(W)) bus_if ();

   multicycle_addsub #(.WIDTH(W), .CHUNK(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one operation, check latency, result and flags, then complete the handshake.
   task automatic run_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic eb,
                         input logic ez, input logic es, input logic eo);
      int waitc;
      int lat;
      waitc = 0;
      while (!bus_if.in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      check_val({tag, ".in_ready"}, bus_if.in_ready, 1);
      bus_if.in_valid = 1'b1;
      bus_if.op       = op;
      bus_if.a        = a;
      bus_if.b        = b;
      @(negedge clk);
      // Scramble inputs after acceptance; they must have no effect.
      bus_if.in_valid = 1'b0;
      bus_if.op       = ~op;
      bus_if.a        = 64'hDEAD_BEEF_CAFE_F00D;
      bus_if.b        = 64'h0123_4567_89AB_CDEF;
      check_val({tag, ".busy_ready"}, bus_if.in_ready, 0);
      lat = 0;
      while (!bus_if.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, ".latency"}, lat, NCH);
      check_val({tag, ".result"}, bus_if.result, er);
      check_val({tag, ".cout"},   bus_if.cout, ec);
      check_val({tag, ".borrow"}, bus_if.borrow, eb);
      check_val({tag, ".zf"},     bus_if.zf, CC & ez);
      check_val({tag, ".sf"},     bus_if.sf, CC & es);
      check_val({tag, ".of"},     bus_if.of, CC & eo);
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check_val({tag, ".vld_clr"},  bus_if.out_valid, 0);
      check_val({tag, ".idle_rdy"}, bus_if.in_ready, 1);
   endtask

   initial begin
      int lat;
      n_checks         = 0;
      n_fail           = 0;
      rst_n            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.op        = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);

      check_val("rst.out_valid", bus_if.out_valid, 0);
      check_val("rst.in_ready",  bus_if.in_ready, 1);
      check_val("rst.result",    bus_if.result, 0);
      check_val("rst.cout",      bus_if.cout, 0);
      check_val("rst.borrow",    bus_if.borrow, 0);
      check_val("rst.flags",     {bus_if.zf, bus_if.sf, bus_if.of}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      //       tag     op    a                       b                       result                  c  b  z  s  o
      run_op("add5p7", 1'b0, 64'd5,                  64'd7,                  64'd12,                 0, 0, 0, 0, 0);
      run_op("sub5m7", 1'b1, 64'd5,                  64'd7,                  64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0, 1, 0);
      run_op("subovf", 1'b1, 64'h8000_0000_0000_0000, 64'd1,                 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 1);
      run_op("addwrap",1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 64'd0,                  1, 0, 1, 0, 0);
      run_op("addovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1);
      run_op("addmid", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,                 64'h0000_0001_0000_0000, 0, 0, 0, 0, 0);
      run_op("subeq",  1'b1, 64'h1234,               64'h1234,               64'd0,                  1, 0, 1, 0, 0);

      // Backpressure in DONE with in_valid toggling.
      bus_if.in_valid = 1'b1;
      bus_if.op       = 1'b0;
      bus_if.a        = 64'd1;
      bus_if.b        = 64'd2;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      lat = 0;
      while (!bus_if.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_val("bp.latency", lat, NCH);
      for (int i = 0; i < 3; i++) begin
         bus_if.in_valid = (i % 2 == 0);
         bus_if.a        = 64'd99;
         bus_if.b        = 64'd1;
         @(negedge clk);
         check_val("bp.hold_result", bus_if.result, 64'd3);
         check_val("bp.hold_valid",  bus_if.out_valid, 1);
         check_val("bp.in_ready",    bus_if.in_ready, 0);
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check_val("bp.vld_clr",  bus_if.out_valid, 0);
      check_val("bp.no_accept", bus_if.in_ready, 1);
      run_op("bp.next", 1'b0, 64'd10, 64'd20, 64'd30, 0, 0, 0, 0, 0);

      // Reset in the 2nd BUSY cycle; also check partial result after chunk 0.
      bus_if.in_valid = 1'b1;
      bus_if.op       = 1'b0;
      bus_if.a        = 64'h0001_0002_0003_0004;
      bus_if.b        = 64'h0010_0020_0030_0040;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      check_val("mid.partial", bus_if.result, 64'h44);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("mid.rst_valid",  bus_if.out_valid, 0);
      check_val("mid.rst_result", bus_if.result, 0);
      check_val("mid.rst_ready",  bus_if.in_ready, 1);
      run_op("post_rst", 1'b0, 64'd3, 64'd4, 64'd7, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
